// File: rtl/mask_byte_serializer_if.sv
// Handshake bundle between the pixel decision stage, the mask byte serializer and the result SRAM.
// The master drives pixels, start and io_valid; the slave is the serializer.
interface mask_byte_serializer_if;
  logic start;
  logic pixel_valid;
  logic is_foreground;
  logic pixel_ready;
  logic write_req;
  logic io_valid;
  logic write_in;
  logic busy;
  logic frame_done;
  logic overflow;
  logic underflow;

  modport master (
    output start,
    output pixel_valid,
    output is_foreground,
    output io_valid,
    input  pixel_ready,
    input  write_req,
    input  write_in,
    input  busy,
    input  frame_done,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  start,
    input  pixel_valid,
    input  is_foreground,
    input  io_valid,
    output pixel_ready,
    output write_req,
    output write_in,
    output busy,
    output frame_done,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/mask_byte_serializer.sv
// Expands per-pixel foreground decisions into 0xFF/0x00 mask bytes and shifts them MSB-first
// into the result SRAM, one bit per io_valid strobe, through a bounded pixel FIFO.
module mask_byte_serializer #(
  parameter int IMG_LENGTH      = 16384,
  parameter int FIFO_DEPTH      = 64,
  parameter int START_THRESHOLD = 32
) (
  input logic                   clk,
  input logic                   reset,
  mask_byte_serializer_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_W = $clog2(IMG_LENGTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(START_THRESHOLD);
  localparam logic [PIX_W-1:0] IMG_C   = PIX_W'(IMG_LENGTH);

  logic [1:0]            state_q, state_d;
  logic [FIFO_DEPTH-1:0] fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PIX_W-1:0]      in_pix_q, in_pix_d;
  logic [PIX_W-1:0]      out_pix_q, out_pix_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  write_req_q, write_req_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic in_run;
  logic fifo_empty;
  logic pixel_ready;
  logic push;
  logic drop;
  logic bit_adv;
  logic pop;
  logic write_in;

  // Handshake decode; acceptance looks only at the registered occupancy, so a full FIFO
  // refuses a pixel even in a cycle where the head is being popped.
  always_comb begin
    in_run      = (state_q == ST_FILL) || (state_q == ST_STREAM);
    fifo_empty  = (count_q == CNT_W'(0));
    pixel_ready = in_run && (count_q < DEPTH_C) && (in_pix_q < IMG_C);
    push        = bus.pixel_valid && pixel_ready;
    drop        = bus.pixel_valid && !pixel_ready && in_run;
    bit_adv     = (state_q == ST_STREAM) && bus.io_valid;
    pop         = bit_adv && (bit_cnt_q == 3'd7) && !fifo_empty;
    if ((state_q == ST_STREAM) && !fifo_empty) begin
      write_in = fifo_mem_q[head_q];
    end else begin
      write_in = 1'b0;
    end
  end

  // Next-state for the FSM, FIFO pointers, frame counters and sticky error flags.
  always_comb begin
    state_d     = state_q;
    fifo_mem_d  = fifo_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    in_pix_d    = in_pix_q;
    out_pix_d   = out_pix_q;
    bit_cnt_d   = bit_cnt_q;
    write_req_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push) begin
      fifo_mem_d[tail_q] = bus.is_foreground;
      tail_d             = tail_q + PTR_W'(1);
      in_pix_d           = in_pix_q + PIX_W'(1);
    end else begin
      tail_d = tail_q;
    end

    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // An empty FIFO still consumes strobes: the SRAM sees a 0x00 byte and the frame keeps moving.
    if (bit_adv) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        out_pix_d = out_pix_q + PIX_W'(1);
      end else begin
        out_pix_d = out_pix_q;
      end
      if (fifo_empty) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_FILL;
          head_d      = PTR_W'(0);
          tail_d      = PTR_W'(0);
          count_d     = CNT_W'(0);
          in_pix_d    = PIX_W'(0);
          out_pix_d   = PIX_W'(0);
          bit_cnt_d   = 3'd0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        // Decided on next-cycle occupancy so write_req lands in the cycle after the enabling push.
        if ((count_d >= THR_C) || (in_pix_d == IMG_C)) begin
          state_d     = ST_STREAM;
          write_req_d = 1'b1;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_STREAM: begin
        if (out_pix_d == IMG_C) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fifo_mem_q  <= {FIFO_DEPTH{1'b0}};
      head_q      <= PTR_W'(0);
      tail_q      <= PTR_W'(0);
      count_q     <= CNT_W'(0);
      in_pix_q    <= PIX_W'(0);
      out_pix_q   <= PIX_W'(0);
      bit_cnt_q   <= 3'd0;
      write_req_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_mem_q  <= fifo_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_pix_q    <= in_pix_d;
      out_pix_q   <= out_pix_d;
      bit_cnt_q   <= bit_cnt_d;
      write_req_q <= write_req_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.pixel_ready = pixel_ready;
  assign bus.write_req   = write_req_q;
  assign bus.write_in    = write_in;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.frame_done  = (state_q == ST_DONE);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
